// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for N requesters with a registered one-hot
// grant, a binary grant index and a valid/ready hold on each grant.
// Optional feature macro: RR_LOCK_EN adds the lock input. When a grant is
// accepted with lock=1 and its request still up, the same requester is granted again.
//
// Handshake: gnt/gnt_idx/gnt_valid are held bit-stable while gnt_valid=1 and
// gnt_ready=0. A transfer happens on a rising edge where gnt_valid & gnt_ready.
// In the cycle of that transfer the next winner is loaded, so grants can be
// issued back-to-back, one per cycle.
module rr_arbiter8 #(
  parameter  int N    = 8,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  input  logic            gnt_ready,
`ifdef RR_LOCK_EN
  input  logic            lock,
`endif
  output logic            dbg_state
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [IDXW-1:0] idx_q, idx_nxt;
  logic [N-1:0]    gnt_q, gnt_nxt;
  logic [IDXW-1:0] arb_ptr;
  logic            do_arb;
  logic [IDXW:0]   pick_res;
  logic            lock_hit;

  // Search req starting at p and wrapping. The MSB of the result flags a winner.
  // The loop runs from the far end down, so the closest set bit is assigned last and wins.
  function automatic logic [IDXW:0] pick(input logic [N-1:0] r,
                                         input logic [IDXW-1:0] p);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] j;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = p + i[IDXW-1:0];
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

`ifdef RR_LOCK_EN
  assign lock_hit = lock & req[idx_q];
`else
  assign lock_hit = 1'b0;
`endif

  // State register: FSM state, priority pointer and the registered grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
      gnt_q <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx_q <= idx_nxt;
      gnt_q <= gnt_nxt;
    end
  end

  // Next-state logic: arbitrate from IDLE, or re-arbitrate after a transfer.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx_q;
    arb_ptr   = ptr;
    do_arb    = 1'b0;
    case (state)
      IDLE: begin
        do_arb = 1'b1;
      end
      GRANT: begin
        if (gnt_ready && !lock_hit) begin
          ptr_nxt = idx_q + IDXW'(1);
          arb_ptr = ptr_nxt;
          do_arb  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pick_res = pick(req, arb_ptr);
    if (do_arb) begin
      if (pick_res[IDXW]) begin
        state_nxt = GRANT;
        idx_nxt   = pick_res[IDXW-1:0];
      end else begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    end
    gnt_nxt = '0;
    if (state_nxt == GRANT) gnt_nxt[idx_nxt] = 1'b1;
  end

  // Output logic: drive everything straight from the registers.
  always_comb begin
    gnt       = gnt_q;
    gnt_idx   = idx_q;
    gnt_valid = (state == GRANT);
    dbg_state = state;
  end

endmodule
